// File: rtl/musicbox_pkg.sv
// Shared playlist constants: track lengths, sequencer state encoding and track index width.
package musicbox_pkg;

  localparam int TRACK_W = 2;

  // Track lengths as m:ss, indexed by track number
  localparam logic [5:0] TRACK_LEN_MIN [0:3] = '{6'd0, 6'd1, 6'd0, 6'd2};
  localparam logic [5:0] TRACK_LEN_SEC [0:3] = '{6'd30, 6'd5, 6'd45, 6'd0};

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    WAIT_CLR = 2'd1,
    STOP     = 2'd2
  } seq_state_e;

endpackage

// File: rtl/playlist_sequencer_if.sv
// Elapsed-time / button inputs and track / remaining-time outputs of the playlist sequencer.
interface playlist_sequencer_if;
  import musicbox_pkg::*;

  logic               ispaused;
  logic [5:0]         minutes;
  logic [5:0]         seconds;
  logic               next_req;
  logic               prev_req;
  logic [TRACK_W-1:0] track;
  logic               ss;
  logic [5:0]         rem_min;
  logic [5:0]         rem_sec;
  logic               song_done;
  logic               stopped;

  modport slave (
    input  ispaused, minutes, seconds, next_req, prev_req,
    output track, ss, rem_min, rem_sec, song_done, stopped
  );

  modport master (
    output ispaused, minutes, seconds, next_req, prev_req,
    input  track, ss, rem_min, rem_sec, song_done, stopped
  );

endinterface

// File: rtl/track_length_rom.sv
// Combinational track index -> track length (m:ss) lookup.
module track_length_rom
  import musicbox_pkg::*;
(
  input  logic [TRACK_W-1:0] track_i,
  output logic [5:0]         len_min_o,
  output logic [5:0]         len_sec_o
);

  assign len_min_o = TRACK_LEN_MIN[track_i];
  assign len_sec_o = TRACK_LEN_SEC[track_i];

endmodule

// File: rtl/playlist_sequencer.sv
// Playlist sequencer: advances tracks on end-of-track or user buttons, toggles ss to
// restart the play-time counter, and reports the remaining time of the current track.
module playlist_sequencer
  import musicbox_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter bit LOOP       = 1'b1
) (
  input  logic                 clk_1hz,
  input  logic                 RESET,
  playlist_sequencer_if.slave  bus
);

  localparam logic [TRACK_W-1:0] LAST = TRACK_W'(NUM_TRACKS - 1);

  seq_state_e         state_q, state_d;
  logic [TRACK_W-1:0] track_q, track_d, trk_inc, trk_dec;
  logic               ss_q, ss_d, done_q, done_d, next_q, prev_q;
  logic               next_rise, prev_rise, btn, at_end, el_zero, illegal;
  logic [5:0]         len_min, len_sec;
  logic               borrow, sat;
  logic [6:0]         rem_min_w, rem_sec_w;

  track_length_rom u_rom (
    .track_i   (track_q),
    .len_min_o (len_min),
    .len_sec_o (len_sec)
  );

  assign next_rise = bus.next_req & ~next_q;
  assign prev_rise = bus.prev_req & ~prev_q;
  assign btn       = next_rise | prev_rise;
  assign trk_inc   = (track_q == LAST) ? '0 : track_q + 1'b1;
  assign trk_dec   = (track_q == '0) ? LAST : track_q - 1'b1;
  // Seconds never exceed 59, so the concatenation orders minutes-then-seconds
  assign at_end    = {bus.minutes, bus.seconds} >= {len_min, len_sec};
  assign el_zero   = (bus.minutes == '0) && (bus.seconds == '0);
  assign illegal   = {1'b0, track_q} >= 3'(NUM_TRACKS);

  always_ff @(posedge clk_1hz or posedge RESET) begin
    if (RESET) begin
      state_q <= PLAY;
      track_q <= '0;
      ss_q    <= 1'b0;
      done_q  <= 1'b0;
      next_q  <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      track_q <= track_d;
      ss_q    <= ss_d;
      done_q  <= done_d;
      next_q  <= bus.next_req;
      prev_q  <= bus.prev_req;
    end
  end

  always_comb begin
    state_d = state_q;
    track_d = track_q;
    ss_d    = ss_q;
    done_d  = 1'b0;
    unique case (state_q)
      PLAY: begin
        if (btn) begin
          track_d = next_rise ? trk_inc : trk_dec;
          ss_d    = ~ss_q;
          state_d = WAIT_CLR;
        end else if (!bus.ispaused && at_end) begin
          done_d = 1'b1;
          if (track_q == LAST && !LOOP) begin
            state_d = STOP;
          end else begin
            track_d = trk_inc;
            ss_d    = ~ss_q;
            state_d = WAIT_CLR;
          end
        end
      end
      // Counter still shows the old track's time until it sees the ss edge
      WAIT_CLR: begin
        if (btn) begin
          track_d = next_rise ? trk_inc : trk_dec;
          ss_d    = ~ss_q;
        end else if (el_zero) begin
          state_d = PLAY;
        end
      end
      STOP: begin
        if (btn) begin
          track_d = next_rise ? '0 : LAST;
          ss_d    = ~ss_q;
          state_d = WAIT_CLR;
        end
      end
      default: state_d = PLAY;
    endcase
    if (illegal) track_d = '0;
  end

  // Borrow subtraction; a set sign bit means elapsed has passed the track length
  always_comb begin
    borrow    = bus.seconds > len_sec;
    rem_sec_w = {1'b0, len_sec} + (borrow ? 7'd60 : 7'd0) - {1'b0, bus.seconds};
    rem_min_w = {1'b0, len_min} - {1'b0, bus.minutes} - {6'd0, borrow};
    sat       = (state_q == STOP) || rem_min_w[6] || rem_sec_w[6];
  end

  assign bus.rem_min   = sat ? '0 : rem_min_w[5:0];
  assign bus.rem_sec   = sat ? '0 : rem_sec_w[5:0];
  assign bus.track     = track_q;
  assign bus.ss        = ss_q;
  assign bus.song_done = done_q;
  assign bus.stopped   = (state_q == STOP);

endmodule
